// File: rtl/seg7_pkg.sv
// Shared constants, types and small helpers for the 4-digit 7-segment scan controller.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] ANODE_OFF = 4'hF;

    // Active-low gfedcba patterns, indexed by nibble value 0..F.
    localparam logic [6:0] SEG_HEX_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef logic [1:0] digit_idx_t;
    typedef logic [3:0] brightness_t;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  digit_en;
        brightness_t brightness;
    } disp_set_t;

    function automatic logic [3:0] anode_select(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

    // Digits above the most-significant non-zero nibble are dropped; digit 0 always stays.
    function automatic logic [3:0] lz_keep_mask(input logic [15:0] value);
        logic [3:0] keep;
        keep[0] = 1'b1;
        keep[1] = (value[15:4] != 12'h000);
        keep[2] = (value[15:8] != 8'h00);
        keep[3] = (value[15:12] != 4'h0);
        return keep;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low 7-segment pattern lookup.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    // Table lookup; every nibble value has an entry so no fallback is needed.
    always_comb begin
        pattern = SEG_HEX_TABLE[nibble];
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan of a 4-digit common-anode display with PWM dimming and frame-synchronous update.
// Optional build macro SEG7_LZ_BLANK_EN enables leading-zero suppression on the displayed value.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int CLK_DIV    = 1024,
    parameter int NUM_DIGITS = 4
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [15:0] value_in,
    input  logic [3:0]  digit_en_in,
    input  logic [3:0]  brightness_in,
    input  logic        update,
    output logic [6:0]  SEG_CATHODE,
    output logic [3:0]  SEG_ANODE,
    output logic        frame_done
);

    localparam int TICK_W  = $clog2(CLK_DIV);
    localparam int SUB_DIV = CLK_DIV / 16;
    localparam int SUB_W   = $clog2(SUB_DIV);

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(CLK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_ZERO  = TICK_W'(0);
    localparam logic [SUB_W-1:0]  SUB_LAST   = SUB_W'(SUB_DIV - 1);
    localparam digit_idx_t        LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

    logic [TICK_W-1:0] tick_cnt_r;
    logic [SUB_W-1:0]  sub_cnt_r;
    brightness_t       phase_r;
    digit_idx_t        digit_idx_r;

    disp_set_t pend_r;
    disp_set_t act_r;
    disp_set_t in_set_s;

    logic [6:0] cathode_r;
    logic [3:0] anode_r;
    logic       frame_done_r;

    logic       tick_wrap_s;
    logic       sub_wrap_s;
    logic       boundary_s;
    logic [3:0] nibble_s;
    logic [6:0] pattern_s;
    logic [3:0] lz_keep_s;
    logic       digit_on_s;
    logic       pwm_on_s;
    logic       guard_s;
    logic       lit_s;
    logic [6:0] cathode_nxt_s;
    logic [3:0] anode_nxt_s;

    assign in_set_s = '{value: value_in, digit_en: digit_en_in, brightness: brightness_in};

    assign tick_wrap_s = (tick_cnt_r == TICK_LAST);
    assign sub_wrap_s  = (sub_cnt_r == SUB_LAST);
    assign boundary_s  = tick_wrap_s && (digit_idx_r == LAST_DIGIT);

    // Slot timing: tick counter, PWM phase (tick / (CLK_DIV/16)) and digit index.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            tick_cnt_r  <= TICK_ZERO;
            sub_cnt_r   <= '0;
            phase_r     <= 4'd0;
            digit_idx_r <= 2'd0;
        end else if (tick_wrap_s) begin
            tick_cnt_r  <= TICK_ZERO;
            sub_cnt_r   <= '0;
            phase_r     <= 4'd0;
            digit_idx_r <= (digit_idx_r == LAST_DIGIT) ? 2'd0 : digit_idx_r + 2'd1;
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
            if (sub_wrap_s) begin
                sub_cnt_r <= '0;
                phase_r   <= phase_r + 4'd1;
            end else begin
                sub_cnt_r <= sub_cnt_r + SUB_W'(1);
            end
        end
    end

    // Pending set follows every update; active set only moves at the frame boundary,
    // taking a same-cycle update directly so it is not delayed by a whole frame.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pend_r <= '0;
            act_r  <= '0;
        end else begin
            if (update) begin
                pend_r <= in_set_s;
            end
            if (boundary_s) begin
                act_r <= update ? in_set_s : pend_r;
            end
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    assign lz_keep_s = lz_keep_mask(act_r.value);
`else
    assign lz_keep_s = 4'hF;
`endif

    assign nibble_s   = act_r.value[{digit_idx_r, 2'b00} +: 4];
    assign digit_on_s = act_r.digit_en[digit_idx_r] & lz_keep_s[digit_idx_r];
    assign pwm_on_s   = (phase_r <= act_r.brightness);
    assign guard_s    = (tick_cnt_r == TICK_ZERO);
    assign lit_s      = digit_on_s && pwm_on_s && !guard_s;

    seg7_hex_decode u_hex_decode (
        .nibble  (nibble_s),
        .pattern (pattern_s)
    );

    // Next pin state from the current slot; dark unless the digit is on and inside its PWM window.
    always_comb begin
        anode_nxt_s   = ANODE_OFF;
        cathode_nxt_s = SEG_BLANK;
        if (lit_s) begin
            anode_nxt_s   = anode_select(digit_idx_r);
            cathode_nxt_s = pattern_s;
        end else begin
            anode_nxt_s   = ANODE_OFF;
            cathode_nxt_s = SEG_BLANK;
        end
    end

    // Registered pins and frame pulse, one cycle behind the counter state.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            anode_r      <= ANODE_OFF;
            cathode_r    <= SEG_BLANK;
            frame_done_r <= 1'b0;
        end else begin
            anode_r      <= anode_nxt_s;
            cathode_r    <= cathode_nxt_s;
            frame_done_r <= boundary_s;
        end
    end

    assign SEG_ANODE   = anode_r;
    assign SEG_CATHODE = cathode_r;
    assign frame_done  = frame_done_r;

endmodule
